// File: rtl/video_tpg_pkg.sv
// Shared types and helpers for the video test-pattern generator.
// Timing fields are zero-extended to a common width so one window helper serves both axes.
package video_tpg_pkg;

    localparam int POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] hs_start;
        logic [POS_W-1:0] hs_end;
        logic [POS_W-1:0] hact_start;
        logic [POS_W-1:0] hact_end;
        logic [POS_W-1:0] h_end;
        logic [POS_W-1:0] vs_start;
        logic [POS_W-1:0] vs_end;
        logic [POS_W-1:0] vact_start;
        logic [POS_W-1:0] vact_end;
        logic [POS_W-1:0] v_end;
    } tpg_timing_t;

    // Half-open [win_start, win_end); an empty or inverted window never matches.
    function automatic logic in_window(input logic [POS_W-1:0] pos,
                                       input logic [POS_W-1:0] win_start,
                                       input logic [POS_W-1:0] win_end);
        return (pos >= win_start) && (pos < win_end);
    endfunction

endpackage

// File: rtl/tpg_raster_cnt.sv
// Horizontal/vertical raster position counters; h wraps after h_end, v advances on each h wrap.
// The >= compares keep both counters bounded if the end values shrink mid-frame.
module tpg_raster_cnt #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_BITS-1:0] h_end,
    input  logic [V_BITS-1:0] v_end,
    output logic [H_BITS-1:0] h,
    output logic [V_BITS-1:0] v
);

    logic [H_BITS-1:0] h_q, h_d;
    logic [V_BITS-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q >= h_end) begin
            h_d = '0;
            if (v_q >= v_end) begin
                v_d = '0;
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h = h_q;
    assign v = v_q;

endmodule

// File: rtl/video_tpg.sv
// Free-running test-pattern source: hs/vs/vld and {R,G,B} decoded from the raster position.
// One cycle from counter to registered pins; no handshake, the stream never stalls.
module video_tpg
    import video_tpg_pkg::*;
#(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_BITS-1:0] tHS_START,
    input  logic [H_BITS-1:0] tHS_END,
    input  logic [H_BITS-1:0] tHACT_START,
    input  logic [H_BITS-1:0] tHACT_END,
    input  logic [H_BITS-1:0] tH_END,
    input  logic [V_BITS-1:0] tVS_START,
    input  logic [V_BITS-1:0] tVS_END,
    input  logic [V_BITS-1:0] tVACT_START,
    input  logic [V_BITS-1:0] tVACT_END,
    input  logic [V_BITS-1:0] tV_END,
    output logic              hs,
    output logic              vs,
    output logic              vld,
    output logic [3*PW-1:0]   rgb
);

    tpg_timing_t       tim;
    logic [H_BITS-1:0] h;
    logic [V_BITS-1:0] v;
    logic [POS_W-1:0]  h_pos, v_pos;
    logic [PW-1:0]     cnt_q, cnt_d, cnt_base;
    logic              hs_q, hs_d, vs_q, vs_d, vld_q, vld_d;
    logic [3*PW-1:0]   rgb_q, rgb_d;

    assign tim = '{hs_start:   POS_W'(tHS_START),
                   hs_end:     POS_W'(tHS_END),
                   hact_start: POS_W'(tHACT_START),
                   hact_end:   POS_W'(tHACT_END),
                   h_end:      POS_W'(tH_END),
                   vs_start:   POS_W'(tVS_START),
                   vs_end:     POS_W'(tVS_END),
                   vact_start: POS_W'(tVACT_START),
                   vact_end:   POS_W'(tVACT_END),
                   v_end:      POS_W'(tV_END)};

    tpg_raster_cnt #(
        .H_BITS (H_BITS),
        .V_BITS (V_BITS)
    ) u_raster (
        .clk   (clk),
        .rst   (rst),
        .h_end (tH_END),
        .v_end (tV_END),
        .h     (h),
        .v     (v)
    );

    always_comb begin
        h_pos = POS_W'(h);
        v_pos = POS_W'(v);
        hs_d  = in_window(h_pos, tim.hs_start, tim.hs_end);
        vs_d  = in_window(v_pos, tim.vs_start, tim.vs_end);
        vld_d = in_window(h_pos, tim.hact_start, tim.hact_end) &&
                in_window(v_pos, tim.vact_start, tim.vact_end);

        // A one-pixel raster sits at the origin every clock, so it must keep counting.
        cnt_base = cnt_q;
        if ((h_pos == '0) && (v_pos == '0) && !((tim.h_end == '0) && (tim.v_end == '0))) begin
            cnt_base = '0;
        end

        cnt_d = cnt_base;
        rgb_d = '0;
        if (vld_d) begin
            cnt_d = cnt_base + 1'b1;
            rgb_d = {cnt_base, PW'(h_pos - tim.hact_start), PW'(v_pos - tim.vact_start)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            vld_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vld_q <= vld_d;
            rgb_q <= rgb_d;
        end
    end

    assign hs  = hs_q;
    assign vs  = vs_q;
    assign vld = vld_q;
    assign rgb = rgb_q;

endmodule

// File: tb/tb_video_tpg.sv
// Directed bench for video_tpg: positional vector table plus reset, degenerate and minimal-raster sequences.
module tb_video_tpg;

    localparam int PW    = 8;
    localparam int FRAME = 2501;
    localparam int LINE  = 61;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic        hs, vs, vld;
    logic [23:0] rgb;

    int total = 0;
    int bad   = 0;

    logic [26:0] log_a [0:2*FRAME-1];
    logic [7:0]  cnt_a [0:2*FRAME-1];
    logic [26:0] log_b [0:FRAME-1];

    typedef struct {
        int          p;
        logic        hs;
        logic        vs;
        logic        vld;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs [0:15];

    video_tpg #(.PW(PW), .H_BITS(12), .V_BITS(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .tHS_START   (tHS_START),
        .tHS_END     (tHS_END),
        .tHACT_START (tHACT_START),
        .tHACT_END   (tHACT_END),
        .tH_END      (tH_END),
        .tVS_START   (tVS_START),
        .tVS_END     (tVS_END),
        .tVACT_START (tVACT_START),
        .tVACT_END   (tVACT_END),
        .tV_END      (tV_END),
        .hs          (hs),
        .vs          (vs),
        .vld         (vld),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_default_timing();
        tHS_START = 10; tHS_END = 20; tHACT_START = 40; tHACT_END = 50; tH_END = 60;
        tVS_START = 11; tVS_END = 21; tVACT_START = 25; tVACT_END = 35; tV_END = 40;
    endtask

    // Leaves rst released 3 ns after an edge, so the next edge evaluates (0,0).
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int hs_n, vs_n, vld_n, leak, mism;

        vecs[0]  = '{p: 0,          hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[1]  = '{p: 9,          hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[2]  = '{p: 10,         hs: 1, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[3]  = '{p: 19,         hs: 1, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[4]  = '{p: 20,         hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[5]  = '{p: 11*LINE,    hs: 0, vs: 1, vld: 0, rgb: 24'h000000};
        vecs[6]  = '{p: 20*LINE+60, hs: 0, vs: 1, vld: 0, rgb: 24'h000000};
        vecs[7]  = '{p: 21*LINE,    hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[8]  = '{p: 25*LINE+40, hs: 0, vs: 0, vld: 1, rgb: 24'h000000};
        vecs[9]  = '{p: 25*LINE+49, hs: 0, vs: 0, vld: 1, rgb: 24'h090900};
        vecs[10] = '{p: 25*LINE+50, hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[11] = '{p: 26*LINE+40, hs: 0, vs: 0, vld: 1, rgb: 24'h0A0001};
        vecs[12] = '{p: 34*LINE+49, hs: 0, vs: 0, vld: 1, rgb: 24'h630909};
        vecs[13] = '{p: 35*LINE+40, hs: 0, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[14] = '{p: FRAME+15,   hs: 1, vs: 0, vld: 0, rgb: 24'h000000};
        vecs[15] = '{p: FRAME+25*LINE+45, hs: 0, vs: 0, vld: 1, rgb: 24'h050500};

        set_default_timing();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hs", hs, 0);
        chk("rst_vs", vs, 0);
        chk("rst_vld", vld, 0);
        chk("rst_rgb", rgb, 0);
        #2 rst = 1'b0;

        for (int p = 0; p < 2*FRAME; p++) begin
            @(posedge clk);
            #1;
            log_a[p] = {hs, vs, vld, rgb};
            cnt_a[p] = dut.cnt_q;
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("vec%0d_p%0d", i, vecs[i].p), log_a[vecs[i].p],
                {vecs[i].hs, vecs[i].vs, vecs[i].vld, vecs[i].rgb});
        end

        hs_n = 0; vs_n = 0; vld_n = 0; leak = 0; mism = 0;
        for (int p = 0; p < FRAME; p++) begin
            hs_n  += int'(log_a[p][26]);
            vs_n  += int'(log_a[p][25]);
            vld_n += int'(log_a[p][24]);
            if (!log_a[p][24] && log_a[p][23:0] != 24'h0) leak++;
            if (log_a[p] != log_a[p+FRAME]) mism++;
        end
        chk("hs_per_frame", hs_n, 41*10);
        chk("vs_per_frame", vs_n, 610);
        chk("vld_per_frame", vld_n, 100);
        chk("rgb_outside_vld", leak, 0);
        chk("frame2_identical", mism, 0);
        chk("cnt_end_frame1", cnt_a[FRAME-1], 100);
        chk("cnt_start_frame2", cnt_a[FRAME], 0);

        // Mid-frame reset, 25 clocks into line 0, held 30 ns.
        do_reset();
        repeat (25) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_outputs", {hs, vs, vld, rgb}, 0);
        chk("midrst_h", dut.u_raster.h_q, 0);
        chk("midrst_cnt", dut.cnt_q, 0);
        #29 rst = 1'b0;
        for (int p = 0; p < FRAME; p++) begin
            @(posedge clk);
            #1;
            log_b[p] = {hs, vs, vld, rgb};
        end
        mism = 0;
        for (int p = 0; p < FRAME; p++) if (log_b[p] != log_a[p]) mism++;
        chk("midrst_replay", mism, 0);

        // Empty hs window and inverted vertical active window.
        rst = 1'b1;
        tHS_START = 20; tHS_END = 20; tVACT_START = 35; tVACT_END = 25;
        do_reset();
        hs_n = 0; vs_n = 0; vld_n = 0;
        for (int p = 0; p < FRAME; p++) begin
            @(posedge clk);
            #1;
            hs_n  += int'(hs);
            vs_n  += int'(vs);
            vld_n += int'(vld);
        end
        chk("degen_hs", hs_n, 0);
        chk("degen_vld", vld_n, 0);
        chk("degen_vs", vs_n, 610);

        // One-pixel raster: every clock is a complete, valid frame.
        rst = 1'b1;
        tHS_START = 0; tHS_END = 1; tHACT_START = 0; tHACT_END = 1; tH_END = 0;
        tVS_START = 0; tVS_END = 1; tVACT_START = 0; tVACT_END = 1; tV_END = 0;
        do_reset();
        mism = 0;
        for (int p = 0; p < 300; p++) begin
            @(posedge clk);
            #1;
            if ({hs, vs, vld} != 3'b111) mism++;
            if (rgb != {8'(p), 16'h0000}) mism++;
        end
        chk("min_raster_stream", mism, 0);
        chk("min_raster_cnt", dut.cnt_q, 300 % 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
